// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage sequential divider:
// state encodings, default widths and {hi,lo} result field positions.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 6;

  localparam int DIV_LO_LSB = 0;
  localparam int DIV_HI_LSB = DIV_W;

  localparam logic [1:0] DIV_IDLE   = 2'd0;
  localparam logic [1:0] DIV_BYZERO = 2'd1;
  localparam logic [1:0] DIV_RUN    = 2'd2;
  localparam logic [1:0] DIV_DONE   = 2'd3;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the EX stage (master)
// and the sequential divider (slave).
interface div_if #(
  parameter int WIDTH = 32
);

  logic               start;
  logic               annul;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall_req;

  modport master (
    output start, annul, signed_div,
    output opdata1, opdata2,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, annul, signed_div,
    input  opdata1, opdata2,
    output result, ready, stall_req
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder,
// trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  rem_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  rem_o,
  output logic              q_o
);

  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shl  = rem_i << 1;
    diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, divisor_i};
    q_o  = ~diff[WIDTH+1];
    if (q_o) begin
      rem_o = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      rem_o = shl;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: one quotient bit per cycle,
// stalls the pipe while busy and returns {remainder, quotient}.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sq_q, sq_d;
  logic               sr_q, sr_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;

  logic [2*WIDTH:0]   step_rem;
  logic               step_q;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   q_raw, r_raw;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    neg1  = bus.signed_div & bus.opdata1[WIDTH-1];
    neg2  = bus.signed_div & bus.opdata2[WIDTH-1];
    abs1  = neg1 ? -bus.opdata1 : bus.opdata1;
    abs2  = neg2 ? -bus.opdata2 : bus.opdata2;
    q_raw = {step_rem[WIDTH-1:1], step_q};
    r_raw = step_rem[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      DIV_IDLE: begin
        rdy_d = 1'b0;
        res_d = '0;
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_RUN;
            rem_d   = {{(WIDTH+1){1'b0}}, abs1};
            dvs_d   = abs2;
            sq_d    = neg1 ^ neg2;
            sr_d    = neg1;
            cnt_d   = '0;
          end
        end
      end
      DIV_BYZERO: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_DONE;
          rdy_d   = 1'b1;
          res_d   = '0;
        end
      end
      DIV_RUN: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          cnt_d = cnt_q + 1'b1;
          // last iteration lands the signed-corrected result directly
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DIV_DONE;
            rdy_d   = 1'b1;
            res_d   = {sr_q ? -r_raw : r_raw,
                       sq_q ? -q_raw : q_raw};
          end
        end
      end
      DIV_DONE: begin
        if (bus.annul || !bus.start) begin
          state_d = DIV_IDLE;
          rdy_d   = 1'b0;
          res_d   = '0;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        rdy_d   = 1'b0;
        res_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.result    = res_q;
  assign bus.ready     = rdy_q;
  assign bus.stall_req = bus.start & ~rdy_q & ~bus.annul;

endmodule
